// File: rtl/id_ex_hazard_stage_if.sv
// Decode-to-execute bundle: decode-side fields in, registered EX-side fields out.
// The master drives decode fields; the slave (the pipeline stage) drives EX fields.
interface id_ex_hazard_stage_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned REG_W  = 4
);
    // Decode side
    logic              valid_i;
    logic [DATA_W-1:0] R2res_i;
    logic [DATA_W-1:0] R3res_i;
    logic [REG_W-1:0]  R2_i;
    logic [REG_W-1:0]  R3_i;
    logic [REG_W-1:0]  DestR_i;
    logic [1:0]        ExtndSel_i;
    logic              VF_i;
    logic              RegWrite_i;
    logic              MemRead_i;
    logic              flush_i;

    // Execute side
    logic              stall_o;
    logic              valid_o;
    logic              RegWrite_o;
    logic              MemRead_o;
    logic              VF_o;
    logic [DATA_W-1:0] R2res_o;
    logic [DATA_W-1:0] R3res_o;
    logic [REG_W-1:0]  R2_o;
    logic [REG_W-1:0]  R3_o;
    logic [REG_W-1:0]  DestR_o;
    logic [1:0]        ExtndSel_o;
    logic [15:0]       stall_cnt_o;

    modport master (
        output valid_i, R2res_i, R3res_i, R2_i, R3_i, DestR_i, ExtndSel_i,
        output VF_i, RegWrite_i, MemRead_i, flush_i,
        input  stall_o, valid_o, RegWrite_o, MemRead_o, VF_o, R2res_o, R3res_o,
        input  R2_o, R3_o, DestR_o, ExtndSel_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, R2res_i, R3res_i, R2_i, R3_i, DestR_i, ExtndSel_i,
        input  VF_i, RegWrite_i, MemRead_i, flush_i,
        output stall_o, valid_o, RegWrite_o, MemRead_o, VF_o, R2res_o, R3res_o,
        output R2_o, R3_o, DestR_o, ExtndSel_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the instruction in decode stalls
// decode for LOAD_STALL cycles, filling EX with bubbles meanwhile. flush_i kills
// the instruction being captured and abandons any stall in progress.
module id_ex_hazard_stage #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned LOAD_STALL = 1   // legal 1..7
) (
    input logic                 clk,
    input logic                 rst,
    id_ex_hazard_stage_if.slave bus
);

    localparam logic IDLE  = 1'b0;
    localparam logic STALL = 1'b1;

    // Remaining stall cycles after the hazard cycle itself
    localparam logic [2:0] CNT_LOAD    = 3'(LOAD_STALL - 1);
    localparam bit         MULTI_STALL = (LOAD_STALL > 1);

    logic       state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic              valid_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              vf_q;
    logic [DATA_W-1:0] r2res_q;
    logic [DATA_W-1:0] r3res_q;
    logic [REG_W-1:0]  r2_q;
    logic [REG_W-1:0]  r3_q;
    logic [REG_W-1:0]  dest_r_q;
    logic [1:0]        extnd_sel_q;
    logic [15:0]       stall_cnt_q;

    logic use2;
    logic use3;
    logic hazard;
    logic stall;
    logic bubble;

    // R3 is only a source for the ExtndSel == 2'b10 encoding
    assign use2 = bus.ExtndSel_i[1];
    assign use3 = bus.ExtndSel_i[1] & ~bus.ExtndSel_i[0];

    // Load in EX whose result the decode instruction needs; register 0 never hazards
    assign hazard = bus.valid_i & valid_q & mem_read_q & reg_write_q
                  & (dest_r_q != '0) & (vf_q == bus.VF_i)
                  & ((use2 & (bus.R2_i == dest_r_q)) | (use3 & (bus.R3_i == dest_r_q)));

    // Next-state, stall and bubble decision; flush overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        if (bus.flush_i) begin
            bubble  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (MULTI_STALL) begin
                            state_d = STALL;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                STALL: begin
                    // EX holds a bubble here, so the hazard is not re-checked
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and stall countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pipeline register: capture decode fields or load an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            vf_q        <= 1'b0;
            r2res_q     <= '0;
            r3res_q     <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            dest_r_q    <= '0;
            extnd_sel_q <= '0;
        end else if (bubble) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            vf_q        <= 1'b0;
            r2res_q     <= '0;
            r3res_q     <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            dest_r_q    <= '0;
            extnd_sel_q <= '0;
        end else begin
            valid_q     <= bus.valid_i;
            reg_write_q <= bus.RegWrite_i;
            mem_read_q  <= bus.MemRead_i;
            vf_q        <= bus.VF_i;
            r2res_q     <= bus.R2res_i;
            r3res_q     <= bus.R3res_i;
            r2_q        <= bus.R2_i;
            r3_q        <= bus.R3_i;
            dest_r_q    <= bus.DestR_i;
            extnd_sel_q <= bus.ExtndSel_i;
        end
    end

    // Saturating count of cycles spent stalling decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.valid_o     = valid_q;
    assign bus.RegWrite_o  = reg_write_q;
    assign bus.MemRead_o   = mem_read_q;
    assign bus.VF_o        = vf_q;
    assign bus.R2res_o     = r2res_q;
    assign bus.R3res_o     = r3res_q;
    assign bus.R2_o        = r2_q;
    assign bus.R3_o        = r3_q;
    assign bus.DestR_o     = dest_r_q;
    assign bus.ExtndSel_o  = extnd_sel_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: three instances (LOAD_STALL = 2, 3, 7) share one
// stimulus stream; a vector table exercises the LOAD_STALL=2 instance, then
// hand sequences cover flush mid-stall, reset mid-stall and counter saturation.
module tb_id_ex_hazard_stage;

    typedef struct packed {
        logic         valid;
        logic [127:0] r2res;
        logic [127:0] r3res;
        logic [3:0]   r2;
        logic [3:0]   r3;
        logic [3:0]   destr;
        logic [1:0]   extnd;
        logic         vf;
        logic         regwrite;
        logic         memread;
        logic         flush;
    } in_t;

    typedef struct packed {
        logic         stall;
        logic         valid;
        logic         regwrite;
        logic         memread;
        logic         vf;
        logic [127:0] r2res;
        logic [127:0] r3res;
        logic [3:0]   r2;
        logic [3:0]   r3;
        logic [3:0]   destr;
        logic [1:0]   extnd;
        logic [15:0]  cnt;
    } obs_t;

    typedef struct {
        in_t         in;
        logic        exp_stall;
        logic        exp_bubble;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV    = 22;
    localparam int SAT_N = 75000;

    logic clk;
    logic rst;
    in_t  drv;
    obs_t obs [3];

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LS = (g == 0) ? 2 : ((g == 1) ? 3 : 7);

        id_ex_hazard_stage_if #(.DATA_W(128), .REG_W(4)) bus_if ();

        assign bus_if.valid_i    = drv.valid;
        assign bus_if.R2res_i    = drv.r2res;
        assign bus_if.R3res_i    = drv.r3res;
        assign bus_if.R2_i       = drv.r2;
        assign bus_if.R3_i       = drv.r3;
        assign bus_if.DestR_i    = drv.destr;
        assign bus_if.ExtndSel_i = drv.extnd;
        assign bus_if.VF_i       = drv.vf;
        assign bus_if.RegWrite_i = drv.regwrite;
        assign bus_if.MemRead_i  = drv.memread;
        assign bus_if.flush_i    = drv.flush;

        id_ex_hazard_stage #(.DATA_W(128), .REG_W(4), .LOAD_STALL(LS)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );

        assign obs[g] = {bus_if.stall_o, bus_if.valid_o, bus_if.RegWrite_o, bus_if.MemRead_o,
                         bus_if.VF_o, bus_if.R2res_o, bus_if.R3res_o, bus_if.R2_o, bus_if.R3_o,
                         bus_if.DestR_o, bus_if.ExtndSel_o, bus_if.stall_cnt_o};
    end

    function automatic in_t mk(logic v, logic [127:0] a, logic [127:0] b, logic [3:0] r2,
                               logic [3:0] r3, logic [3:0] d, logic [1:0] e, logic vf,
                               logic rw, logic mr, logic fl);
        in_t t;
        t.valid = v;  t.r2res = a;  t.r3res = b;  t.r2 = r2;  t.r3 = r3;  t.destr = d;
        t.extnd = e;  t.vf = vf;  t.regwrite = rw;  t.memread = mr;  t.flush = fl;
        return t;
    endfunction

    function automatic obs_t exp_reg(in_t i, logic bubble, logic [15:0] cnt);
        obs_t e;
        e = '0;
        if (!bubble) begin
            e.valid = i.valid;  e.regwrite = i.regwrite;  e.memread = i.memread;
            e.vf = i.vf;  e.r2res = i.r2res;  e.r3res = i.r3res;  e.r2 = i.r2;
            e.r3 = i.r3;  e.destr = i.destr;  e.extnd = i.extnd;
        end
        e.cnt = cnt;
        return e;
    endfunction

    function automatic obs_t reg_part(obs_t o);
        obs_t r;
        r = o;
        r.stall = 1'b0;
        return r;
    endfunction

    // Stalls accumulated after n edges of a self-dependent load stream
    function automatic logic [15:0] exp_stalls(int l, int n);
        int s;
        int rem;
        rem = (n - 1) % (l + 1);
        s = l * ((n - 1) / (l + 1)) + ((rem < l) ? rem : l);
        if (s > 65535) s = 65535;
        return 16'(s);
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Hold reset over two edges, release at a falling edge with idle inputs
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drv = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t tbl [NV];

    initial begin
        logic [127:0] pa, pb, la, lb, ua, ub;
        in_t ld, use_r2, r3_use, r3_no, vf_x, ld_r0, use_r0, non_ld, inv, use_fl, ld_self;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        drv   = '0;

        pa = {16{8'hA5}};
        pb = 128'h0000_1234_0000_5678_0000_9ABC_0000_DEF0;
        la = {4{32'h1111_0001}};
        lb = {4{32'h2222_0002}};
        ua = {4{32'h3333_0003}};
        ub = {4{32'h4444_0004}};

        ld      = mk(1, la, lb, 4'd1, 4'd2, 4'd4, 2'b00, 1, 1, 1, 0);
        use_r2  = mk(1, ua, ub, 4'd4, 4'd9, 4'd6, 2'b11, 1, 1, 0, 0);
        r3_use  = mk(1, ua, ub, 4'd7, 4'd4, 4'd6, 2'b10, 1, 1, 0, 0);
        r3_no   = mk(1, ua, ub, 4'd7, 4'd4, 4'd6, 2'b11, 1, 1, 0, 0);
        vf_x    = mk(1, ua, ub, 4'd4, 4'd9, 4'd6, 2'b11, 0, 1, 0, 0);
        ld_r0   = mk(1, la, lb, 4'd1, 4'd2, 4'd0, 2'b00, 1, 1, 1, 0);
        use_r0  = mk(1, ua, ub, 4'd0, 4'd0, 4'd6, 2'b11, 1, 1, 0, 0);
        non_ld  = mk(1, la, lb, 4'd1, 4'd2, 4'd4, 2'b00, 1, 1, 0, 0);
        inv     = mk(0, ua, ub, 4'd4, 4'd9, 4'd6, 2'b11, 1, 1, 0, 0);
        use_fl  = mk(1, ua, ub, 4'd4, 4'd9, 4'd6, 2'b11, 1, 1, 0, 1);
        ld_self = mk(1, la, lb, 4'd4, 4'd2, 4'd4, 2'b11, 1, 1, 1, 0);

        // {inputs, stall_o before edge, bubble after edge, stall_cnt_o after edge}
        tbl[0]  = '{mk(1, pa, pb, 4'd3, 4'd0, 4'd5, 2'b11, 0, 1, 0, 0), 0, 0, 16'd0};
        tbl[1]  = '{ld,     0, 0, 16'd0};
        tbl[2]  = '{use_r2, 1, 1, 16'd1};
        tbl[3]  = '{use_r2, 1, 1, 16'd2};
        tbl[4]  = '{use_r2, 0, 0, 16'd2};
        tbl[5]  = '{ld,     0, 0, 16'd2};
        tbl[6]  = '{r3_use, 1, 1, 16'd3};
        tbl[7]  = '{r3_use, 1, 1, 16'd4};
        tbl[8]  = '{r3_use, 0, 0, 16'd4};
        tbl[9]  = '{ld,     0, 0, 16'd4};
        tbl[10] = '{r3_no,  0, 0, 16'd4};
        tbl[11] = '{ld,     0, 0, 16'd4};
        tbl[12] = '{vf_x,   0, 0, 16'd4};
        tbl[13] = '{ld_r0,  0, 0, 16'd4};
        tbl[14] = '{use_r0, 0, 0, 16'd4};
        tbl[15] = '{non_ld, 0, 0, 16'd4};
        tbl[16] = '{use_r2, 0, 0, 16'd4};
        tbl[17] = '{ld,     0, 0, 16'd4};
        tbl[18] = '{inv,    0, 0, 16'd4};
        tbl[19] = '{ld,     0, 0, 16'd4};
        tbl[20] = '{use_fl, 0, 1, 16'd4};
        tbl[21] = '{use_r2, 0, 0, 16'd4};

        // Reset state on every instance
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_obs($sformatf("reset_dut%0d", k), obs[k], '0);
        @(negedge clk);
        rst = 1'b1;

        // Vector table against the LOAD_STALL=2 instance
        for (int i = 0; i < NV; i++) begin
            drv = tbl[i].in;
            #1;
            check_bit($sformatf("v%0d_stall", i), obs[0].stall, tbl[i].exp_stall);
            @(posedge clk);
            #1;
            check_obs($sformatf("v%0d_regs", i), reg_part(obs[0]),
                      exp_reg(tbl[i].in, tbl[i].exp_bubble, tbl[i].exp_cnt));
            @(negedge clk);
        end

        // Flush in the 2nd stall cycle of the LOAD_STALL=3 instance
        do_reset();
        drv = ld;
        @(posedge clk);
        @(negedge clk);
        drv = use_r2;
        #1 check_bit("fl_stall_first", obs[1].stall, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drv = use_fl;
        #1 check_bit("fl_stall_flushed", obs[1].stall, 1'b0);
        @(posedge clk);
        #1;
        check_bit("fl_valid_bubble", obs[1].valid, 1'b0);
        check_cnt("fl_cnt", obs[1].cnt, 16'd1);
        @(negedge clk);
        drv = use_r2;
        #1 check_bit("fl_back_idle", obs[1].stall, 1'b0);
        @(posedge clk);
        #1;
        check_bit("fl_capture_valid", obs[1].valid, 1'b1);
        check_cnt("fl_capture_r2", {12'd0, obs[1].r2}, 16'd4);
        check_cnt("fl_cnt_after", obs[1].cnt, 16'd1);

        // Asynchronous reset while the LOAD_STALL=7 instance is mid-stall
        do_reset();
        drv = ld;
        @(posedge clk);
        @(negedge clk);
        drv = use_r2;
        @(posedge clk);
        @(negedge clk);
        #1 check_bit("mr_stalling", obs[2].stall, 1'b1);
        rst = 1'b0;
        #1 check_obs("mr_reset_state", obs[2], '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_bit("mr_release_stall", obs[2].stall, 1'b0);

        // Back-to-back self-dependent loads: exact stall totals and saturation
        do_reset();
        drv = ld_self;
        repeat (SAT_N) @(posedge clk);
        #1;
        check_cnt("sat_ls2", obs[0].cnt, exp_stalls(2, SAT_N));
        check_cnt("sat_ls3", obs[1].cnt, exp_stalls(3, SAT_N));
        check_cnt("sat_ls7", obs[2].cnt, exp_stalls(7, SAT_N));
        repeat (16) @(posedge clk);
        #1 check_cnt("sat_hold", obs[2].cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

Decode-to-execute pipeline register of the vector ASIP, with load-use hazard detection. It captures decoded operands and control from decode and presents them to the forwarding unit and execute stage. When the next instruction reads a register that an in-flight vector load has not yet produced, it stalls upstream for a configurable number of cycles and inserts bubbles. It also provides flush (taken branch) and a saturating stall-cycle counter.

## Interface
- DATA_W, 128, operand width (vector register data)
- REG_W, 4, register index width
- LOAD_STALL, 1, bubble cycles per load-use hazard (legal 1..7)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- valid_i  input  1  decode slot holds a real instruction
- R2res_i, R3res_i  input  DATA_W  source operand values read in decode
- R2_i, R3_i  input  REG_W  source register indices
- DestR_i  input  REG_W  destination register index
- ExtndSel_i  input  2  operand-usage select: bit1=R2 used; R3 used only when 2'b10
- VF_i  input  1  1 = vector register file, 0 = scalar
- RegWrite_i, MemRead_i  input  1  write-back enable, load instruction
- flush_i  input  1  kill the instruction being captured this cycle
- stall_o  output  1  hold IF/ID this cycle (combinational)
- valid_o, RegWrite_o, MemRead_o, VF_o  output  1  registered copies
- R2res_o, R3res_o  output  DATA_W  registered operands (to forwarding unit)
- R2_o, R3_o, DestR_o  output  REG_W  registered indices
- ExtndSel_o  output  2  registered select
- stall_cnt_o  output  16  saturating count of stall cycles

## Operation
- Usage terms:
  - use2 = ExtndSel_i[1]
  - use3 = ExtndSel_i[1] & ~ExtndSel_i[0]
- Hazard condition:
  - hazard = valid_i & valid_o & MemRead_o & RegWrite_o & (DestR_o != 0) & (VF_o == VF_i) & ((use2 & R2_i == DestR_o) | (use3 & R3_i == DestR_o))
  - Register 0 never causes a hazard.
- Bubble: valid_o, RegWrite_o and MemRead_o go to 0; all data, index and select outputs go to 0.
- FSM states IDLE and STALL, plus a 3-bit cnt.
- IDLE:
  - With no hazard and no flush: capture all inputs; stall_o=0.
  - On hazard (and no flush): stall_o=1 and load a bubble.
  - If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1; otherwise stay in IDLE.
- STALL:
  - stall_o=1 and load a bubble each cycle; cnt decrements.
  - When cnt==1, return to IDLE after this cycle.
  - Hazard is not re-evaluated in STALL, because the EX register holds a bubble.
- flush_i has highest priority in any state:
  - Load a bubble; stall_o=0; FSM goes to IDLE; cnt=0.
- stall_cnt_o increments by 1 on every cycle with stall_o=1 and saturates at 16'hFFFF.
- Upstream guarantee: decode inputs stay stable while stall_o=1. The stalled instruction is captured on the first cycle with stall_o=0.

## Timing
- Reset (rst=0, asynchronous):
  - All outputs 0; FSM in IDLE; cnt=0; stall_cnt_o=0.
  - Release is synchronous to the next rising edge.
- Latency: an input is visible on the outputs 1 cycle after capture.
- stall_o is combinational from the current inputs and registered state, in the same cycle as the hazard. Total stall = exactly LOAD_STALL cycles.
- Once LOAD_STALL bubbles are in flight, the load result reaches the forwarding stage's Res/Res1 paths.
- Flush during STALL: the remaining stall cycles are dropped; the next cycle runs in IDLE.
- Reset asserted mid-stall: immediate return to the reset state; stall_o=0 while rst=0.
- Back-to-back loads: a load captured after a stall can itself trigger a new hazard in the following IDLE cycle.

## Test plan
- Reset then pass-through: assert rst=0 for 2 cycles; all outputs are 0. Release, then drive valid_i=1, R2res_i=128'hA5.., R2_i=3, DestR_i=5. Next cycle the outputs equal the inputs and stall_o=0.
- Load-use on R2, LOAD_STALL=2:
  - Cycle 0: EX holds a load, DestR_o=4, VF_o=1.
  - Decode: R2_i=4, ExtndSel_i=2'b11, VF_i=1.
  - Expected: stall_o=1 for 2 cycles with valid_o=0 in both; the instruction is captured in cycle 2; stall_cnt_o=2.
- R3 usage gating: same load as above with R3_i=4 and R2_i=7.
  - ExtndSel_i=2'b10: stall.
  - ExtndSel_i=2'b11: no stall.
- No hazard:
  - VF_i=0 against VF_o=1 with matching indices: no stall.
  - DestR_o=0: no stall.
  - MemRead_o=0: no stall.
- Flush mid-stall with LOAD_STALL=3: assert flush_i in the 2nd stall cycle. stall_o=0 that cycle, valid_o=0 next cycle, FSM in IDLE, stall_cnt_o=1.
- Counter saturation: preload via 65535+ stall cycles; stall_cnt_o stays at 16'hFFFF.
